// File: rtl/fairy_wb_stage.sv
// fairy_wb_stage: writeback stage of the fairy MIPS pipeline.
//
// This stage registers the memory-stage outputs and commits GPR writes.
// It owns HI/LO and a CP0 subset (BadVAddr, Count, Status, Cause, EPC).
// It prioritises exceptions and ERET and drives the flush/redirect
// signals back to the earlier stages.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   inst_i .. illegal_*   instruction, PC, data and status from the mem stage
//   reg_we_o/waddr/wdata  committed GPR write
//   hi_o, lo_o            HI/LO registers
//   exception_o, eret_o   pipeline flush requests
//   redirect_pc_o         EXC_VECTOR on an exception, otherwise EPC
//   epc_o                 EPC register
//   debug_wb_pc           PC of the committing instruction (0 for a bubble)
module fairy_wb_stage #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter logic [31:0] STATUS_RESET = 32'h00400000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] data_i,
  input  logic [31:0] mem_addr_i,
  input  logic [63:0] hilo_wdata_i,
  input  logic [1:0]  hilo_we_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        reg_we_i,
  input  logic        delayslot_i,
  input  logic        overflow_i,
  input  logic        unaligned_addr_i,
  input  logic        illegal_inst_i,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        exception_o,
  output logic        eret_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] epc_o,
  output logic [31:0] debug_wb_pc
);

  localparam logic [4:0]  CP0_BADVADDR  = 5'd8;
  localparam logic [4:0]  CP0_COUNT     = 5'd9;
  localparam logic [4:0]  CP0_STATUS    = 5'd12;
  localparam logic [4:0]  CP0_CAUSE     = 5'd13;
  localparam logic [4:0]  CP0_EPC       = 5'd14;
  localparam logic [31:0] STATUS_WMASK  = 32'h0000FF03;
  localparam logic [31:0] CAUSE_WMASK   = 32'h00000300;

  // WB pipeline register
  logic        wb_valid;
  logic [31:0] wb_inst, wb_pc, wb_data, wb_mem_addr;
  logic [63:0] wb_hilo_wdata;
  logic [1:0]  wb_hilo_we;
  logic [4:0]  wb_waddr;
  logic        wb_we, wb_delayslot, wb_overflow, wb_unaligned, wb_illegal;

  // architectural state
  logic [31:0] hi, lo, badvaddr, count, status, cause, epc;
  logic        count_tog;

  always_ff @(posedge clk) begin
    if (reset || exception_o || eret_o) begin
      wb_valid      <= 1'b0;
      wb_inst       <= '0;
      wb_pc         <= '0;
      wb_data       <= '0;
      wb_mem_addr   <= '0;
      wb_hilo_wdata <= '0;
      wb_hilo_we    <= '0;
      wb_waddr      <= '0;
      wb_we         <= 1'b0;
      wb_delayslot  <= 1'b0;
      wb_overflow   <= 1'b0;
      wb_unaligned  <= 1'b0;
      wb_illegal    <= 1'b0;
    end else begin
      wb_valid      <= 1'b1;
      wb_inst       <= inst_i;
      wb_pc         <= pc_i;
      wb_data       <= data_i;
      wb_mem_addr   <= mem_addr_i;
      wb_hilo_wdata <= hilo_wdata_i;
      wb_hilo_we    <= hilo_we_i;
      wb_waddr      <= reg_waddr_i;
      wb_we         <= reg_we_i;
      wb_delayslot  <= delayslot_i;
      wb_overflow   <= overflow_i;
      wb_unaligned  <= unaligned_addr_i;
      wb_illegal    <= illegal_inst_i;
    end
  end

  // decode
  logic [5:0] op, funct;
  logic [4:0] rs, rd;
  logic       is_mfc0, is_mtc0, is_syscall, is_break, is_eret, is_load, is_store;

  assign op         = wb_inst[31:26];
  assign rs         = wb_inst[25:21];
  assign rd         = wb_inst[15:11];
  assign funct      = wb_inst[5:0];
  assign is_mfc0    = (op == 6'b010000) && (rs == 5'b00000);
  assign is_mtc0    = (op == 6'b010000) && (rs == 5'b00100);
  assign is_syscall = (op == 6'b000000) && (funct == 6'b001100);
  assign is_break   = (op == 6'b000000) && (funct == 6'b001101);
  assign is_eret    = (wb_inst == 32'h42000018);
  assign is_load    = (op == 6'b100000) || (op == 6'b100100) || (op == 6'b100001) ||
                      (op == 6'b100101) || (op == 6'b100011) || (op == 6'b100010) ||
                      (op == 6'b100110);
  assign is_store   = (op == 6'b101000) || (op == 6'b101001) || (op == 6'b101011) ||
                      (op == 6'b101010) || (op == 6'b101110);

  // exception priority
  logic        exc_hit, exc_addr;
  logic [4:0]  exc_code;
  logic [31:0] exc_badvaddr;

  always_comb begin
    exc_hit      = 1'b0;
    exc_addr     = 1'b0;
    exc_code     = '0;
    exc_badvaddr = '0;
    if (wb_valid) begin
      if (wb_pc[1:0] != 2'b00) begin
        exc_hit = 1'b1; exc_addr = 1'b1; exc_code = 5'd4; exc_badvaddr = wb_pc;
      end else if (wb_illegal) begin
        exc_hit = 1'b1; exc_code = 5'd10;
      end else if (wb_overflow) begin
        exc_hit = 1'b1; exc_code = 5'd12;
      end else if (is_syscall) begin
        exc_hit = 1'b1; exc_code = 5'd8;
      end else if (is_break) begin
        exc_hit = 1'b1; exc_code = 5'd9;
      end else if (wb_unaligned && is_load) begin
        exc_hit = 1'b1; exc_addr = 1'b1; exc_code = 5'd4; exc_badvaddr = wb_mem_addr;
      end else if (wb_unaligned && is_store) begin
        exc_hit = 1'b1; exc_addr = 1'b1; exc_code = 5'd5; exc_badvaddr = wb_mem_addr;
      end
    end
  end

  logic        commit, mtc0_commit;
  logic [31:0] cp0_rdata;

  assign commit      = wb_valid && !exc_hit;
  assign mtc0_commit = commit && is_mtc0;

  always_comb begin
    cp0_rdata = '0;
    case (rd)
      CP0_BADVADDR: cp0_rdata = badvaddr;
      CP0_COUNT:    cp0_rdata = count;
      CP0_STATUS:   cp0_rdata = status;
      CP0_CAUSE:    cp0_rdata = cause;
      CP0_EPC:      cp0_rdata = epc;
      default:      cp0_rdata = '0;
    endcase
  end

  assign exception_o   = exc_hit;
  assign eret_o        = wb_valid && is_eret && !exc_hit;
  assign reg_we_o      = commit && wb_we;
  assign reg_waddr_o   = wb_waddr;
  assign reg_wdata_o   = is_mfc0 ? cp0_rdata : wb_data;
  assign redirect_pc_o = exc_hit ? EXC_VECTOR : epc;
  assign epc_o         = epc;
  assign hi_o          = hi;
  assign lo_o          = lo;
  assign debug_wb_pc   = wb_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi        <= '0;
      lo        <= '0;
      badvaddr  <= '0;
      count     <= '0;
      count_tog <= 1'b0;
      status    <= STATUS_RESET;
      cause     <= '0;
      epc       <= '0;
    end else begin
      if (mtc0_commit && rd == CP0_COUNT) begin
        count     <= wb_data;
        count_tog <= 1'b0;
      end else begin
        count_tog <= ~count_tog;
        if (count_tog) count <= count + 32'd1;
      end

      if (exc_hit) begin
        cause[6:2] <= exc_code;
        // A nested exception (EXL already set) keeps the original EPC and BD.
        if (!status[1]) begin
          epc       <= wb_delayslot ? wb_pc - 32'd4 : wb_pc;
          cause[31] <= wb_delayslot;
        end
        status[1] <= 1'b1;
        if (exc_addr) badvaddr <= exc_badvaddr;
      end else if (wb_valid) begin
        if (eret_o) status[1] <= 1'b0;
        if (mtc0_commit) begin
          case (rd)
            CP0_STATUS: status <= (status & ~STATUS_WMASK) | (wb_data & STATUS_WMASK);
            CP0_CAUSE:  cause  <= (cause & ~CAUSE_WMASK) | (wb_data & CAUSE_WMASK);
            CP0_EPC:    epc    <= wb_data;
            default:    ;
          endcase
        end
        case (wb_hilo_we)
          2'b11: begin
            hi <= wb_hilo_wdata[63:32];
            lo <= wb_hilo_wdata[31:0];
          end
          2'b10:   hi <= wb_data;
          2'b01:   lo <= wb_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/fairy_wb_stage.md
Name: fairy_wb_stage

Overview:
Final (writeback) stage of the fairy MIPS pipeline, directly downstream of the memory stage. Registers the memory stage's outputs and commits GPR writes. Owns the HI/LO registers and a CP0 subset (BadVAddr, Count, Status, Cause, EPC). Detects and prioritises exceptions and ERET, and drives the flush/redirect signals back to all earlier stages.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect PC on any exception
STATUS_RESET, 32'h00400000, Status reset value (BEV=1, EXL=0)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_i  in  32  instruction from mem stage
pc_i  in  32  PC from mem stage
data_i  in  32  result/load data from mem stage
mem_addr_i  in  32  effective address of the load/store, for BadVAddr
hilo_wdata_i  in  64  MULT/DIV result {HI,LO}
hilo_we_i  in  2  [1]=HI write, [0]=LO write
reg_waddr_i  in  5  GPR destination
reg_we_i  in  1  GPR write enable
delayslot_i  in  1  instruction is in a branch delay slot
overflow_i  in  1  arithmetic overflow
unaligned_addr_i  in  1  unaligned data access
illegal_inst_i  in  1  reserved instruction
reg_we_o  out  1  GPR write enable (committed)
reg_waddr_o  out  5  GPR write address
reg_wdata_o  out  32  GPR write data
hi_o  out  32  HI register
lo_o  out  32  LO register
exception_o  out  1  flush pipeline, redirect to EXC_VECTOR
eret_o  out  1  flush pipeline, redirect to epc_o
redirect_pc_o  out  32  EXC_VECTOR if exception_o, else EPC
epc_o  out  32  EPC register
debug_wb_pc  out  32  PC of the committing instruction (0 for a bubble)

Behaviour:
- Reset: WB register holds a bubble (all fields 0). HI=LO=0, BadVAddr=0, Count=0, Cause=0, EPC=0, Status=STATUS_RESET. All outputs are 0 except hi_o/lo_o (0) and epc_o (0).
- WB register: samples every *_i at each posedge. Loads a bubble when reset, exception_o or eret_o is high in that cycle; this squashes the instruction arriving from the mem stage.
- Latency: an instruction sampled at edge k drives reg_*_o, exception_o and eret_o combinationally during cycle k+1. HI/LO/CP0 update at edge k+1.
- Decode, on the registered inst:
  - MFC0: opcode 010000, rs=00000. Result is CP0[rd] (sel 0).
  - MTC0: opcode 010000, rs=00100. Writes GPR[rt] (supplied on data_i) to CP0[rd].
  - SYSCALL: funct 001100. BREAK: funct 001101. Both have opcode 0.
  - ERET: exactly 32'h42000018.
  - Loads: opcodes 100000/100100/100001/100101/100011/100010/100110. Stores: opcodes 101000/101001/101011/101010/101110.
- Exception priority, highest first. ExcCode and BadVAddr per case:
  - pc[1:0]!=0: AdEL (4), BadVAddr=pc.
  - illegal_inst: RI (10).
  - overflow: Ov (12).
  - SYSCALL: Sys (8).
  - BREAK: Bp (9).
  - unaligned_addr on a load: AdEL (4), BadVAddr=mem_addr. On a store: AdES (5), BadVAddr=mem_addr.
- exception_o = any of the above on a non-bubble. When high:
  - reg_we_o=0 and HI/LO unchanged.
  - Cause.ExcCode[6:2] <= code; Cause.BD[31] <= delayslot.
  - EPC <= delayslot ? pc-4 : pc, only if Status.EXL was 0. If EXL was already 1, EPC and BD are unchanged.
  - Status.EXL[1] <= 1.
  - BadVAddr is updated only for AdEL/AdES.
- eret_o = ERET && !exception_o. At the edge it clears Status.EXL. redirect_pc_o=EPC.
- Commit, when no exception: reg_we_o=reg_we, reg_waddr_o=reg_waddr.
  - reg_wdata_o = CP0 read for MFC0, else data.
  - MFC0 of an unimplemented register reads 0.
- HI/LO writes:
  - hilo_we=11: {HI,LO} <= hilo_wdata.
  - hilo_we=10: HI <= data.
  - hilo_we=01: LO <= data.
- MTC0 write masks:
  - Status: only bits 15:8 and 1:0 are writable.
  - Cause: only bits 9:8 are writable.
  - EPC, Count: full 32 bits.
  - BadVAddr: read-only.
- Count: internal toggle flop; Count increments on every second clock and wraps 32'hFFFFFFFF→0. An MTC0 to Count wins over the increment in the same cycle and resets the toggle.
- MTC0 to Status clearing EXL and ERET in the same instruction window: MTC0 commits at its own edge, and ERET sees the updated value.
- Reset asserted mid-operation overrides every pending write, including an exception in the same cycle.

Test Plan:
1. ADDU with reg_we=1, waddr=5, data=32'h1234 sampled at edge k → cycle k+1: reg_we_o=1, reg_waddr_o=5, reg_wdata_o=32'h1234, debug_wb_pc=pc.
2. overflow_i=1, pc=32'hBFC00100, delayslot=1 → exception_o=1, reg_we_o=0, redirect_pc_o=32'hBFC00380. Next cycle: EPC=32'hBFC000FC, Cause=32'h80000030, Status.EXL=1, WB register holds a bubble.
3. LW with unaligned_addr=1, mem_addr=32'h80000002 → ExcCode=4 and BadVAddr=32'h80000002. An SW in the same case → ExcCode=5.
4. Second exception (SYSCALL) while EXL=1 → EPC is unchanged, ExcCode=8.
5. ERET with EPC=32'hBFC00200 → eret_o=1, redirect_pc_o=32'hBFC00200. Next cycle EXL=0. An ERET with illegal_inst=1 → exception_o=1 and eret_o=0.
6. MULT hilo_we=11, hilo_wdata=64'h1_00000002 → HI=1, LO=2. Then MTC0 Count=32'hFFFFFFFF → Count wraps to 0 two clocks later. MFC0 of Count returns the live value.
